// File: rtl/riscv_program_loader_if.sv
// riscv_program_loader_if: byte stream input and imem write port of the program loader
interface riscv_program_loader_if #(
  parameter int NUM_INST = 128
) ();
  localparam int AW = $clog2(NUM_INST);
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master (input byte_in, byte_valid, output byte_ready, imem_we, imem_addr, imem_wdata);
  modport slave (output byte_in, byte_valid, input byte_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/riscv_program_loader.sv
// riscv_program_loader: assembles LE bytes into imem words and holds the core in reset until loaded; LOADER_CHECKSUM_EN adds a checksum trailer check
module riscv_program_loader #(
  parameter int NUM_INST = 128,
  parameter int INST_WIDTH = 32,
  localparam int AW = $clog2(NUM_INST),
  localparam int CW = $clog2(NUM_INST + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [CW-1:0] word_count,
  riscv_program_loader_if.master bus,
  output logic core_rstn,
  output logic busy,
  output logic done,
  output logic error
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, DONE = 3'd2, ERROR = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd4;
  logic [31:0] sum;
`endif
  logic [2:0] state;
  logic [1:0] lane;
  logic [INST_WIDTH-9:0] part;
  logic [CW-1:0] cnt, idx;
  logic hs, can_start, bad_count;
  logic [INST_WIDTH-1:0] word;
  assign hs = bus.byte_valid && bus.byte_ready;
  // bytes shift in from the top so the first byte ends up in bits [7:0]
  assign word = {bus.byte_in, part};
  assign can_start = start && (state == IDLE || state == DONE || state == ERROR);
  assign bad_count = word_count == '0 || word_count > CW'(NUM_INST);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane <= '0;
      part <= '0;
      cnt <= '0;
      idx <= '0;
      bus.byte_ready <= 1'b0;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
      core_rstn <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      if (hs) begin
        lane <= lane + 2'd1;
        part <= word[INST_WIDTH-1:8];
      end
      if (can_start) begin
        lane <= '0;
        part <= '0;
        idx <= '0;
        cnt <= word_count;
        core_rstn <= 1'b0;
        done <= 1'b0;
        state <= bad_count ? ERROR : LOAD;
        error <= bad_count;
        busy <= !bad_count;
        bus.byte_ready <= !bad_count;
`ifdef LOADER_CHECKSUM_EN
        sum <= '0;
`endif
      end else if (state == LOAD) begin
        if (hs && lane == 2'd3) begin
          bus.imem_we <= 1'b1;
          bus.imem_wdata <= word;
          bus.imem_addr <= idx[AW-1:0];
          idx <= idx + CW'(1);
`ifdef LOADER_CHECKSUM_EN
          sum <= sum + word;
`else
          if (idx == cnt - CW'(1)) bus.byte_ready <= 1'b0;
`endif
        end
        // idx already points past the last word while its write strobe is out
        if (bus.imem_we && idx == cnt) begin
`ifdef LOADER_CHECKSUM_EN
          state <= CHECK;
`else
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      else if (state == CHECK) begin
        if (hs && lane == 2'd3) begin
          bus.byte_ready <= 1'b0;
          busy <= 1'b0;
          state <= word == sum ? DONE : ERROR;
          done <= word == sum;
          error <= word != sum;
        end
      end
`endif
      else if (state == DONE) begin
        core_rstn <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_riscv_program_loader.sv
// tb_riscv_program_loader: directed self-checking bench for riscv_program_loader
module tb_riscv_program_loader;
  localparam int NUM_INST = 128;
  localparam int CW = $clog2(NUM_INST + 1);
  logic clk = 1'b0;
  logic rst, start;
  logic [CW-1:0] word_count;
  logic core_rstn, busy, done, error;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, nw = 0, hs_cycle = 0, base = 0;
  int wa [0:255];
  logic [31:0] wd [0:255];
  int wc [0:255];
  logic [31:0] run_sum;

  riscv_program_loader_if #(.NUM_INST(NUM_INST)) bus ();

  riscv_program_loader #(.NUM_INST(NUM_INST)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word_count(word_count),
    .bus(bus),
    .core_rstn(core_rstn),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.imem_we) begin
    wa[nw] = int'(bus.imem_addr);
    wd[nw] = bus.imem_wdata;
    wc[nw] = cyc;
    nw++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    word_count = CW'(n);
    run_sum = '0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) tick();
    end
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 20) begin
      tick();
      n++;
    end
    check("byte_ready", 32'(bus.byte_ready), 32'd1);
    hs_cycle = cyc;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    run_sum = run_sum + w;
  endtask

  task automatic finish_load();
    int n = 0;
`ifdef LOADER_CHECKSUM_EN
    send_word(run_sum, 0);
`endif
    bus.byte_valid = 1'b0;
    while (!done && !error && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int h0, h1;
    logic [31:0] w3 [0:2];
    w3[0] = 32'h00100093;
    w3[1] = 32'h00200113;
    w3[2] = 32'h002081b3;
    rst = 1'b1;
    start = 1'b0;
    word_count = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    run_sum = '0;
    repeat (2) tick();
    check("rst_ready", 32'(bus.byte_ready), 0);
    check("rst_we", 32'(bus.imem_we), 0);
    check("rst_addr", 32'(bus.imem_addr), 0);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_core_rstn", 32'(core_rstn), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    rst = 1'b0;
    tick();

    // two words, back to back
    do_start(2);
    check("go_busy", 32'(busy), 1);
    check("go_core_rstn", 32'(core_rstn), 0);
    base = nw;
    send_word(32'h00100093, 0);
    h0 = hs_cycle;
    send_word(32'h00200113, 0);
    h1 = hs_cycle;
`ifndef LOADER_CHECKSUM_EN
    bus.byte_valid = 1'b0;
    check("last_we", 32'(bus.imem_we), 1);
    check("done_early", 32'(done), 0);
    tick();
    check("done_set", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_core_rstn0", 32'(core_rstn), 0);
    check("done_ready", 32'(bus.byte_ready), 0);
    tick();
    check("done_core_rstn1", 32'(core_rstn), 1);
`else
    finish_load();
    tick();
`endif
    check("w2_done", 32'(done), 1);
    check("w2_count", 32'(nw - base), 2);
    check("w2_addr0", 32'(wa[base]), 0);
    check("w2_data0", wd[base], 32'h00100093);
    check("w2_cyc0", 32'(wc[base]), 32'(h0 + 1));
    check("w2_addr1", 32'(wa[base+1]), 1);
    check("w2_data1", wd[base+1], 32'h00200113);
    check("w2_cyc1", 32'(wc[base+1]), 32'(h1 + 1));

    // illegal counts
    base = nw;
    do_start(0);
    check("zero_error", 32'(error), 1);
    check("zero_done", 32'(done), 0);
    check("zero_core_rstn", 32'(core_rstn), 0);
    do_start(NUM_INST + 1);
    check("over_error", 32'(error), 1);
    check("over_busy", 32'(busy), 0);
    repeat (3) tick();
    check("bad_no_write", 32'(nw - base), 0);
    check("bad_ready", 32'(bus.byte_ready), 0);

    // three words with random gaps and a stray start mid-load
    do_start(3);
    check("gap_error_clr", 32'(error), 0);
    base = nw;
    send_word(w3[0], 2);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    word_count = '0;
    tick();
    start = 1'b0;
    check("busy_start_err", 32'(error), 0);
    check("busy_start_busy", 32'(busy), 1);
    send_word(w3[1], 2);
    send_word(w3[2], 2);
    finish_load();
    tick();
    check("gap_done", 32'(done), 1);
    check("gap_count", 32'(nw - base), 3);
    for (int i = 0; i < 3; i++) begin
      check("gap_addr", 32'(wa[base+i]), 32'(i));
      check("gap_data", wd[base+i], w3[i]);
    end

    // restart from DONE, then reset in the middle of word 1
    do_start(2);
    check("restart_core_rstn", 32'(core_rstn), 0);
    check("restart_done", 32'(done), 0);
    base = nw;
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_writes", 32'(nw - base), 1);
    check("mid_rst_data0", wd[base], 32'h11223344);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_core_rstn", 32'(core_rstn), 0);
    check("mid_rst_ready", 32'(bus.byte_ready), 0);
    bus.byte_in = 8'haa;
    bus.byte_valid = 1'b1;
    repeat (3) tick();
    check("idle_not_ready", 32'(bus.byte_ready), 0);
    check("idle_no_write", 32'(nw - base), 1);
    do_start(1);
    send_word(32'hdeadbeef, 0);
    finish_load();
    check("reload_done", 32'(done), 1);
    check("reload_count", 32'(nw - base), 2);
    check("reload_addr", 32'(wa[base+1]), 0);
    check("reload_data", wd[base+1], 32'hdeadbeef);

    // full depth
    do_start(NUM_INST);
    base = nw;
    for (int i = 0; i < NUM_INST; i++) send_word(32'h10000000 + 32'(i), 0);
    finish_load();
    check("full_done", 32'(done), 1);
    check("full_count", 32'(nw - base), NUM_INST);
    check("full_mid_addr", 32'(wa[base+64]), 64);
    check("full_last_addr", 32'(wa[base+NUM_INST-1]), NUM_INST - 1);
    check("full_last_data", wd[base+NUM_INST-1], 32'h10000000 + 32'(NUM_INST - 1));

`ifdef LOADER_CHECKSUM_EN
    do_start(2);
    base = nw;
    send_word(32'h00000001, 0);
    send_word(32'h00000002, 0);
    send_word(32'h00000003, 0);
    bus.byte_valid = 1'b0;
    tick();
    check("ck_good_done", 32'(done), 1);
    check("ck_good_error", 32'(error), 0);
    check("ck_good_core_rstn", 32'(core_rstn), 1);
    check("ck_good_writes", 32'(nw - base), 2);
    do_start(2);
    send_word(32'h00000001, 0);
    send_word(32'h00000002, 0);
    send_word(32'h00000004, 0);
    bus.byte_valid = 1'b0;
    repeat (2) tick();
    check("ck_bad_error", 32'(error), 1);
    check("ck_bad_done", 32'(done), 0);
    check("ck_bad_core_rstn", 32'(core_rstn), 0);
    check("ck_bad_writes", 32'(nw - base), 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
